// File: rtl/alu_seq.sv
// Handshaked ALU with iterative shift-add multiply and restoring divide.
// Build option: define ALU_SEQ_DIV_EN to compile in the iterative divider (DIV/REM).

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | MUL/DIV/REM iterating, one step per cycle
// DONE  | result presented, held until out_ready
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_REM = 4'hE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;
  logic             accept;

  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             sc_ovf;
  logic             sc_err;
  logic             sc_iter;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] nx_hi;
  logic [WIDTH-1:0] nx_lo;
  logic [WIDTH-1:0] fin_res;
  logic             fin_ovf;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
`endif

  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle results, computed straight from the operands being accepted
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_err   = 1'b0;
    sc_iter  = 1'b0;
    add_full = {1'b0, in_a} + {1'b0, in_b};
    sub_full = {1'b0, in_a} - {1'b0, in_b};
    case (in_op)
      4'h0: begin
        sc_res   = add_full[WIDTH-1:0];
        sc_carry = add_full[WIDTH];
        sc_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (add_full[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'h1: begin
        sc_res   = sub_full[WIDTH-1:0];
        sc_carry = sub_full[WIDTH];
        sc_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_full[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_MUL: sc_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        if (in_b == '0) begin
          sc_res = '1;
          sc_err = 1'b1;
          sc_ovf = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
      OP_REM: begin
        if (in_b == '0) begin
          sc_res = in_a;
          sc_err = 1'b1;
          sc_ovf = 1'b1;
        end else begin
          sc_iter = 1'b1;
        end
      end
`endif
      4'h4: sc_res = in_a & in_b;
      4'h5: sc_res = in_a | in_b;
      4'h6: sc_res = in_a ^ in_b;
      4'h7: sc_res = ~in_a;
      4'h8: sc_res = {in_a[WIDTH-2:0], 1'b0};
      4'h9: sc_res = {1'b0, in_a[WIDTH-1:1]};
      4'hA: sc_res = {in_a[WIDTH-2:0], in_a[WIDTH-1]};
      4'hB: sc_res = {in_a[0], in_a[WIDTH-1:1]};
      4'hC: sc_res = {{(WIDTH-1){1'b0}}, in_a > in_b};
      4'hD: sc_res = {{(WIDTH-1){1'b0}}, in_a == in_b};
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration step; the final step feeds the result registers directly
  always_comb begin
    nx_hi   = acc_hi;
    nx_lo   = acc_lo;
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
`ifdef ALU_SEQ_DIV_EN
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_rem   = div_shift[WIDTH-1:0] - b_q;
`endif
    if (op_q == OP_MUL) begin
      nx_hi = mul_sum[WIDTH:1];
      nx_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
`ifdef ALU_SEQ_DIV_EN
    else begin
      nx_hi = div_ge ? div_rem : div_shift[WIDTH-1:0];
      nx_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
`endif
    fin_res = (op_q == OP_REM) ? nx_hi : nx_lo;
    fin_ovf = (op_q == OP_MUL) && (nx_hi != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      b_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q <= in_op;
            a_q  <= in_a;
`ifdef ALU_SEQ_DIV_EN
            b_q  <= in_b;
`endif
            if (sc_iter) begin
              acc_hi    <= '0;
              acc_lo    <= (in_op == OP_MUL) ? in_b : in_a;
              cnt       <= CW'(WIDTH - 1);
              out_valid <= 1'b0;
              state     <= BUSY;
            end else begin
              out_res   <= sc_res;
              out_carry <= sc_carry;
              out_ovf   <= sc_ovf;
              out_err   <= sc_err;
              out_zero  <= (sc_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        BUSY: begin
          acc_hi <= nx_hi;
          acc_lo <= nx_lo;
          if (cnt == '0) begin
            out_res   <= fin_res;
            out_carry <= 1'b0;
            out_ovf   <= fin_ovf;
            out_err   <= 1'b0;
            out_zero  <= (fin_res == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases plus randomized traffic against
// an arithmetic reference model; honours ALU_SEQ_DIV_EN like the design.
module tb_alu_seq;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [3:0]   in_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_res;
  logic         out_carry, out_ovf, out_zero, out_err;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_err(out_err)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         carry, ovf, zero, err;
    int           lat;
    int           t0;
    logic [3:0]   op;
  } exp_t;

  exp_t         sbq[$];
  exp_t         e_h;
  exp_t         e_new;
  bit           head_seen = 1'b0;
  logic [W+3:0] held;
  logic [W+3:0] cur;
  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    int     ua, ub, sa, sbv, s, r;
    longint p;
    ua = int'(a);
    ub = int'(b);
    sa  = (ua >= M / 2) ? ua - M : ua;
    sbv = (ub >= M / 2) ? ub - M : ub;
    e.carry = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1; e.t0 = 0; e.op = op;
    r = 0;
    case (op)
      4'h0: begin r = ua + ub; e.carry = (r >= M); s = sa + sbv; e.ovf = (s >= M / 2) || (s < -M / 2); end
      4'h1: begin r = ua - ub + M; e.carry = (ua < ub); s = sa - sbv; e.ovf = (s >= M / 2) || (s < -M / 2); end
      4'h2: begin p = longint'(ua) * longint'(ub); r = int'(p % M); e.ovf = (p >= M); e.lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
      4'h3: if (ub == 0) begin r = M - 1; e.err = 1'b1; e.ovf = 1'b1; end
            else begin r = ua / ub; e.lat = W + 1; end
      4'hE: if (ub == 0) begin r = ua; e.err = 1'b1; e.ovf = 1'b1; end
            else begin r = ua % ub; e.lat = W + 1; end
`else
      4'h3, 4'hE: e.err = 1'b1;
`endif
      4'h4: r = ua & ub;
      4'h5: r = ua | ub;
      4'h6: r = ua ^ ub;
      4'h7: r = M - 1 - ua;
      4'h8: r = ua * 2;
      4'h9: r = ua / 2;
      4'hA: r = (ua * 2) % M + ua / (M / 2);
      4'hB: r = ua / 2 + (ua % 2) * (M / 2);
      4'hC: r = (ua > ub) ? 1 : 0;
      4'hD: r = (ua == ub) ? 1 : 0;
      default: e.err = 1'b1;
    endcase
    r = r % M;
    e.res  = r[W-1:0];
    e.zero = (r == 0);
    return e;
  endfunction

  // Monitor first (pops on handoff), then record any accept happening at the coming edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        cur = {out_res, out_carry, out_ovf, out_zero, out_err};
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL spurious_out_valid: got result %0h with nothing expected", cur);
        end else begin
          e_h = sbq[0];
          if (!head_seen) begin
            chk($sformatf("latency op%0h", e_h.op), 64'(cyc - e_h.t0), 64'(e_h.lat));
            held = cur;
            head_seen = 1'b1;
          end else begin
            chk("held_stable", cur, held);
          end
          if (out_ready) begin
            chk($sformatf("result op%0h", e_h.op), cur, {e_h.res, e_h.carry, e_h.ovf, e_h.zero, e_h.err});
            void'(sbq.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        e_new = model(in_op, in_a, in_b);
        e_new.t0 = cyc;
        sbq.push_back(e_new);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit rnd);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    while (!got) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
      if (!got && n > 300) begin
        checks++;
        $display("FAIL issue_timeout: op %0h not accepted after %0d cycles", op, n);
        break;
      end
    end
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_op = 4'($urandom);
  endtask

  task automatic idle_cycles(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sbq.size());
    end
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) begin
      checks++;
      $display("FAIL out_valid_timeout: got out_valid=0, expected 1");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    int           n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_flags", {out_carry, out_ovf, out_zero, out_err}, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Back-to-back single-cycle ops with consumer always ready
    out_ready = 1'b1;
    issue(4'h0, 8'h7F, 8'h01, 1'b0);
    issue(4'h1, 8'h10, 8'h20, 1'b0);
    issue(4'hD, 8'h33, 8'h33, 1'b0);
    issue(4'hF, 8'h12, 8'h34, 1'b0);
    issue(4'hA, 8'h81, 8'h00, 1'b0);
    drain();

    // MUL: in_ready must stay low for the whole iteration
    issue(4'h2, 8'h10, 8'h10, 1'b0);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (out_valid) break;
      chk("busy_in_ready", in_ready, 0);
      n++;
    end
    drain();

    issue(4'h3, 8'd200, 8'd7, 1'b0);
    issue(4'hE, 8'd200, 8'd7, 1'b0);
    issue(4'h3, 8'd5, 8'd0, 1'b0);
    issue(4'hE, 8'd9, 8'd0, 1'b0);
    issue(4'h2, 8'hFF, 8'hFF, 1'b0);
    drain();

    // Backpressure, then handoff and new accept on the same edge
    out_ready = 1'b0;
    issue(4'h0, 8'h12, 8'h34, 1'b0);
    wait_out_valid();
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'h6; in_a = 8'hA5; in_b = 8'h0F;
    @(negedge clk);
    chk("handoff_and_accept", {out_valid, in_ready}, 2'b11);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a multiply
    issue(4'h2, 8'h5A, 8'h3C, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_res", out_res, 0);
    chk("midrst_flags", {out_carry, out_ovf, out_zero, out_err}, 0);
    sbq.delete();
    head_seen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(4'h0, 8'd3, 8'd4, 1'b0);
    drain();

    // Randomized traffic with random gaps and random consumer stalls
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom);
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(rop, ra, rb, 1'b1);
      idle_cycles($urandom_range(0, 2), 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit registered ALU. It supports arbitrary operand width, adds valid/ready flow control on both sides, and computes multiply, divide and remainder iteratively over WIDTH cycles. All other operations complete in one cycle. It sits between an operand-issue stage and a result consumer, and holds each result stable until the consumer accepts it.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- in_op  in  4  operation code.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts; handoff occurs when out_valid && out_ready.
- out_res  out  WIDTH  result.
- out_carry  out  1  carry (ADD) or borrow (SUB); 0 for all other ops.
- out_ovf  out  1  overflow flag.
- out_zero  out  1  out_res == 0.
- out_err  out  1  illegal op or divide fault.

## Operation
- Opcodes:
  - 0 ADD a+b.
  - 1 SUB a-b.
  - 2 MUL: low WIDTH bits of a*b.
  - 3 DIV: a/b.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 NOT a.
  - 8 SHL a by 1, zero fill.
  - 9 SHR a by 1, zero fill.
  - A ROL a.
  - B ROR a.
  - C GT: 1 if a>b, unsigned.
  - D EQ: 1 if a==b.
  - E REM: a%b.
  - F reserved.
- ADD/SUB: out_ovf is signed overflow, i.e. operands have the same sign for ADD (opposite sign for SUB) and the result sign differs from a.
- SUB: out_carry = 1 iff a<b.
- MUL: shift-add, one partial product per cycle. out_ovf = 1 iff the upper WIDTH bits of the full 2·WIDTH product are nonzero.
- DIV/REM: restoring division, one quotient bit per cycle.
- Divide by zero (b==0, DIV or REM): no iteration. Results: DIV out_res = all ones; REM out_res = a. Flags: out_err=1, out_ovf=1.
- Opcode F: out_res=0, out_err=1, latency 1.
- out_ovf=0 and out_err=0 for all ops not named above. out_zero is always valid with out_res.
- FSM:
  - IDLE: in_ready=1. On accept, a single-cycle op goes to DONE; MUL, or DIV/REM with b≠0, goes to BUSY with iteration count 0.
  - BUSY: in_ready=0. Iterates WIDTH cycles, then goes to DONE.
  - DONE: out_valid=1. If out_ready is 0, hold. If out_ready=1 and in_valid=1, accept the new op in the same cycle (in_ready = out_ready in DONE) and go to DONE or BUSY per the new op. If out_ready=1 and in_valid=0, go to IDLE.
- Operands and op are captured on accept. Later input changes have no effect on the op in progress.

## Timing
- Reset values: out_valid=0, out_res=0, all flags 0, state IDLE. While rst is high, no transfer occurs in either direction.
- Single-cycle ops: out_valid rises on the first edge after the accept edge (latency 1).
- MUL, DIV/REM with b≠0: out_valid rises WIDTH+1 edges after the accept edge.
- Throughput for single-cycle ops is 1 per cycle while out_ready is held high.
- out_res and flags are stable from out_valid rising until the handoff edge.
- rst asserted mid-BUSY or in DONE: outputs return to reset values immediately and the pending result is discarded.

## Configuration
- ALU_SEQ_DIV_EN defined: iterative divider compiled in; DIV/REM behave as specified.
- ALU_SEQ_DIV_EN undefined: no divider logic. DIV and REM behave as opcode F: out_res=0, out_err=1, latency 1.

## Test plan
- ADD a=0x7F, b=0x01 (WIDTH=8) -> out_res=0x80, out_carry=0, out_ovf=1, out_zero=0; out_valid exactly 1 cycle after accept.
- SUB a=0x10, b=0x20 -> out_res=0xF0, out_carry=1, out_ovf=0. Then EQ a=b=0x33 -> out_res=0x01.
- MUL a=0x10, b=0x10 -> out_res=0x00, out_ovf=1, out_zero=1; out_valid 9 cycles after accept; in_ready=0 throughout BUSY.
- DIV a=200, b=7 -> 0x1C. REM a=200, b=7 -> 0x04. DIV a=5, b=0 -> out_res=0xFF, out_err=1, out_ovf=1, latency 1. With ALU_SEQ_DIV_EN undefined, DIV a=200, b=7 -> out_res=0, out_err=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result -> result stable and in_ready=0. Then raise out_ready with in_valid=1 -> new op accepted on the same edge as the handoff.
- Assert rst at iteration 4 of a MUL -> out_valid=0 and out_res=0 immediately. After release, ADD 3+4 -> 0x07.
